// File: rtl/pixel_readout_pkg.sv
// Shared types for the pixel readout path: pixel and word typedefs plus serialiser states.
package pixel_readout_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NLANES = 4;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef pixel_t [NLANES-1:0] word_t;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } ro_state_t;

endpackage

// File: rtl/pixel_readout_fifo.sv
// Synchronous FIFO of captured pixel words. A push while full is ignored unless a pop
// frees the head slot in the same cycle.
module pixel_readout_fifo
  import pixel_readout_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  word_t wdata,
  input  logic  pop,
  output word_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  word_t           mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic            do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr_q[AddrW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pixel_readout.sv
// Captures the pixel lanes during the read phase, buffers whole words and serialises them
// into a valid/ready pixel stream with start/end-of-frame markers.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned READS_PER_FRAME = 1,
  parameter int unsigned FCNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read,
  input  logic [NLANES*DATA_W-1:0] lane_in,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic                     overflow,
  output logic [FCNT_W-1:0]        frame_cnt,
  output logic                     busy
);

  localparam int unsigned LaneW = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int unsigned RcW   = (READS_PER_FRAME > 1) ? $clog2(READS_PER_FRAME) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(NLANES - 1);
  localparam logic [RcW-1:0]   LastRc   = RcW'(READS_PER_FRAME - 1);

  logic              read_q;
  word_t             shadow_q;
  logic              push, pop, full, empty;
  word_t             head;
  ro_state_t         state_q, state_d;
  word_t             word_q, word_d;
  logic [LaneW-1:0]  lane_q, lane_d;
  logic [RcW-1:0]    rc_q, rc_d;
  logic              overflow_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              hs, last_lane;

  // Shadow tracks the lanes while read is high; its last value is pushed on the falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      read_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      read_q <= read;
      if (read) shadow_q <= lane_in;
    end
  end

  assign push = read_q & ~read;

  pixel_readout_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata(shadow_q),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  assign out_valid = (state_q == StSend);
  assign hs        = out_valid & out_ready;
  assign last_lane = (lane_q == LastLane);
  assign out_data  = word_q[lane_q];
  assign out_sof   = out_valid & (rc_q == '0) & (lane_q == '0);
  assign out_eof   = out_valid & (rc_q == LastRc) & last_lane;
  assign overflow  = overflow_q;
  assign frame_cnt = fcnt_q;
  assign busy      = out_valid | ~empty | read_q;

  // Serialiser next state: walk lanes on each handshake, refill from the FIFO without a bubble
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lane_d  = lane_q;
    rc_d    = rc_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          word_d  = head;
          lane_d  = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (hs) begin
          if (!last_lane) begin
            lane_d = lane_q + LaneW'(1);
          end else begin
            // rc is the in-frame index of the next popped word
            rc_d = (rc_q == LastRc) ? '0 : rc_q + RcW'(1);
            if (!empty) begin
              pop    = 1'b1;
              word_d = head;
              lane_d = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Serialiser registers, sticky overflow and frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      word_q     <= '0;
      lane_q     <= '0;
      rc_q       <= '0;
      overflow_q <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      rc_q    <= rc_d;
      if (push & full & ~pop) overflow_q <= 1'b1;
      if (hs & out_eof)       fcnt_q     <= fcnt_q + FCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pixel_readout.sv
// Self-checking bench for pixel_readout: per-word scoreboard plus directed corner sequences.
module tb_pixel_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_a, read_b;
  logic [31:0] lane_in;
  logic        out_ready;

  logic [7:0]  a_data, b_data;
  logic        a_valid, a_sof, a_eof, a_ovf, a_busy;
  logic        b_valid, b_sof, b_eof, b_ovf, b_busy;
  logic [1:0]  a_fcnt;
  logic [15:0] b_fcnt;

  always #5 clk = ~clk;

  pixel_readout #(
    .DEPTH(4), .READS_PER_FRAME(1), .FCNT_W(2)
  ) dut_a (
    .clk(clk), .reset(reset), .read(read_a), .lane_in(lane_in),
    .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
    .out_sof(a_sof), .out_eof(a_eof), .overflow(a_ovf), .frame_cnt(a_fcnt), .busy(a_busy)
  );

  pixel_readout #(
    .DEPTH(4), .READS_PER_FRAME(2), .FCNT_W(16)
  ) dut_b (
    .clk(clk), .reset(reset), .read(read_b), .lane_in(lane_in),
    .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
    .out_sof(b_sof), .out_eof(b_eof), .overflow(b_ovf), .frame_cnt(b_fcnt), .busy(b_busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } pix_t;

  typedef struct {
    logic [31:0] word;
    int          len;
    logic [3:0]  pat;
    logic [1:0]  fcnt;
  } vec_t;

  pix_t qa[$];
  pix_t qb[$];
  vec_t tbl[5];

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [3:0] ready_pat;
  int         b_hs = 0, b_first = 0, b_last = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    out_ready = ready_pat[cyc % 4];
    cyc++;
  endtask

  task automatic exp_word(input bit to_b, input logic [31:0] w, input bit first, input bit last);
    pix_t p;
    for (int j = 0; j < 4; j++) begin
      p.d   = w[8*j +: 8];
      p.sof = first && (j == 0);
      p.eof = last && (j == 3);
      if (to_b) qb.push_back(p);
      else qa.push_back(p);
    end
  endtask

  task automatic latency(input string tag);
    int lat;
    bit done;
    lat  = -1;
    done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge clk);
      if (a_valid) begin
        lat  = k;
        done = 1'b1;
      end else begin
        step();
      end
    end
    check(tag, lat, 2);
  endtask

  task automatic drain(input bit b, input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if ((b ? qb.size() : qa.size()) == 0 && !(b ? b_busy : a_busy)) done = 1'b1;
      else step();
    end
    check({tag, "_drain"}, done, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    qa.delete();
    qb.delete();
    repeat (2) step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] mkword(input int k);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(16 * k + j + 1);
    return w;
  endfunction

  // Scoreboard for dut_a: every accepted pixel must match the queue head
  always @(negedge clk) begin
    if (!reset && a_valid && out_ready) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_extra_pixel: got 0x%0h, expected no pixel", a_data);
      end else begin
        pix_t e;
        e = qa.pop_front();
        check("a_data", a_data, e.d);
        check("a_sof", a_sof, e.sof);
        check("a_eof", a_eof, e.eof);
      end
    end
  end

  // Scoreboard for dut_b, also recording handshake cycles for the bubble check
  always @(negedge clk) begin
    if (!reset && b_valid && out_ready) begin
      if (b_hs == 0) b_first = cyc;
      b_last = cyc;
      b_hs++;
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_extra_pixel: got 0x%0h, expected no pixel", b_data);
      end else begin
        pix_t e;
        e = qb.pop_front();
        check("b_data", b_data, e.d);
        check("b_sof", b_sof, e.sof);
        check("b_eof", b_eof, e.eof);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w5;
    tbl[0] = '{word: 32'h44332211, len: 3, pat: 4'hF,    fcnt: 2'd1};
    tbl[1] = '{word: 32'h88776655, len: 1, pat: 4'b1010, fcnt: 2'd2};
    tbl[2] = '{word: 32'hDDCCBBAA, len: 2, pat: 4'b0110, fcnt: 2'd3};
    tbl[3] = '{word: 32'h0F1E2D3C, len: 1, pat: 4'hF,    fcnt: 2'd0};
    tbl[4] = '{word: 32'hA5A55A5A, len: 4, pat: 4'b1001, fcnt: 2'd1};

    reset     = 1'b1;
    read_a    = 1'b0;
    read_b    = 1'b0;
    lane_in   = '0;
    out_ready = 1'b0;
    ready_pat = 4'hF;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", a_valid, 0);
    check("rst_data", a_data, 0);
    check("rst_sof", a_sof, 0);
    check("rst_eof", a_eof, 0);
    check("rst_overflow", a_ovf, 0);
    check("rst_frame_cnt", a_fcnt, 0);
    check("rst_busy", a_busy, 0);
    check("rst_b_valid", b_valid, 0);

    // Single-word frames with varied read length and ready patterns; frame_cnt wraps at 2 bits
    for (int i = 0; i < 5; i++) begin
      ready_pat = tbl[i].pat;
      exp_word(1'b0, tbl[i].word, 1'b1, 1'b1);
      read_a  = 1'b1;
      lane_in = tbl[i].word;
      repeat (tbl[i].len) step();
      read_a = 1'b0;
      latency("latency");
      drain(1'b0, "vec");
      check("vec_frame_cnt", a_fcnt, tbl[i].fcnt);
      check("vec_idle_busy", a_busy, 0);
      step();
    end

    // Overflow: one word sits in the output register, DEPTH more fill the FIFO, the next drops
    ready_pat = 4'h0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        @(negedge clk);
        check("ovf_before_drop", a_ovf, 0);
        check("ovf_busy", a_busy, 1);
      end
      if (k < 5) exp_word(1'b0, mkword(k), 1'b1, 1'b1);
      read_a  = 1'b1;
      lane_in = mkword(k);
      step();
      read_a = 1'b0;
      step();
    end
    @(negedge clk);
    check("ovf_set", a_ovf, 1);
    ready_pat = 4'hF;
    drain(1'b0, "ovf");
    check("ovf_sticky", a_ovf, 1);
    check("ovf_frame_cnt", a_fcnt, 2'd1);

    // Reset while the second pixel of a word is on the bus
    ready_pat = 4'h0;
    step();
    w5 = 32'hC4C3C2C1;
    exp_word(1'b0, w5, 1'b1, 1'b1);
    read_a  = 1'b1;
    lane_in = w5;
    step();
    read_a = 1'b0;
    latency("rst_mid_latency");
    ready_pat = 4'hF;
    step();
    ready_pat = 4'h0;
    step();
    @(negedge clk);
    check("mid_pix2_valid", a_valid, 1);
    check("mid_pix2_data", a_data, 8'hC2);
    check("mid_queue_left", qa.size(), 3);
    reset = 1'b1;
    qa.delete();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", a_valid, 0);
    check("mid_rst_overflow", a_ovf, 0);
    check("mid_rst_frame_cnt", a_fcnt, 0);
    check("mid_rst_busy", a_busy, 0);
    ready_pat = 4'hF;
    exp_word(1'b0, 32'hD4D3D2D1, 1'b1, 1'b1);
    read_a  = 1'b1;
    lane_in = 32'hD4D3D2D1;
    step();
    read_a = 1'b0;
    drain(1'b0, "fresh");
    check("fresh_frame_cnt", a_fcnt, 2'd1);

    // Two-word frame on dut_b: markers only at frame edges, no bubble between words
    exp_word(1'b1, 32'hA3A2A1A0, 1'b1, 1'b0);
    exp_word(1'b1, 32'hB3B2B1B0, 1'b0, 1'b1);
    read_b  = 1'b1;
    lane_in = 32'hA3A2A1A0;
    step();
    read_b = 1'b0;
    step();
    read_b  = 1'b1;
    lane_in = 32'hB3B2B1B0;
    step();
    read_b = 1'b0;
    drain(1'b1, "rpf2");
    check("rpf2_frame_cnt", b_fcnt, 16'd1);
    check("rpf2_pixels", b_hs, 8);
    check("rpf2_no_bubble", b_last - b_first, 7);
    check("rpf2_overflow", b_ovf, 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
